ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
Two-master, one-slave arbiter that shares data_ram between the CPU data port (M0) and a second bus master (M1, e.g. the debug/program loader).
- Sits in the minimal SOPC between the openmips ram_* ports, the loader and data_ram0.
- Grants are registered and each grant is a single-cycle access; a master sees ack in the cycle its access hits the RAM.
- Round-robin fairness by default; the CPU stalls on its own request until it is acked.

Parameters:
- ADDR_W, 32, address width (matches RegBus).
- DATA_W, 32, data width (matches RegBus).
- SEL_W, 4, byte-select width (DATA_W/8).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high (RstEnable).
- m0_ce_i  in  1  M0 request (CPU ram_ce_o).
- m0_we_i  in  1  M0 write enable.
- m0_addr_i  in  ADDR_W  M0 address.
- m0_sel_i  in  SEL_W  M0 byte selects.
- m0_data_i  in  DATA_W  M0 write data.
- m0_data_o  out  DATA_W  read data to M0.
- m0_ack_o  out  1  M0 access performed this cycle.
- m0_stall_o  out  1  m0_ce_i & ~m0_ack_o; goes to CPU stall request.
- m1_ce_i, m1_we_i, m1_addr_i, m1_sel_i, m1_data_i, m1_data_o, m1_ack_o  same as M0 (no stall output).
- ram_ce_o  out  1  to data_ram ce.
- ram_we_o  out  1  to data_ram we.
- ram_addr_o  out  ADDR_W  to data_ram addr.
- ram_sel_o  out  SEL_W  to data_ram sel.
- ram_data_o  out  DATA_W  to data_ram data_i.
- ram_data_i  in  DATA_W  from data_ram data_o (combinational read).

Behaviour:
- FSM states: IDLE, GNT_M0, GNT_M1. State is registered; all ram_* outputs are combinational muxes of the granted master.
- Eligible requests in cycle N: eligX = mX_ce_i & ~mX_ack_o. A master acked in cycle N cannot be granted in N+1.
- Next state:
  - No eligible request -> IDLE.
  - One eligible request -> grant that master.
  - Both eligible -> grant the master that was not last granted.
- last_gnt register: updates on every entry to GNT_Mx; reset value 1, so M0 wins the first tie.
- In GNT_Mx:
  - ram_ce_o = mX_ce_i.
  - ram_we_o, ram_addr_o, ram_sel_o and ram_data_o come from Mx.
  - mX_ack_o = mX_ce_i.
- If the granted master dropped ce, the cycle is wasted: ram_ce_o = 0, no ack.
- In IDLE: ram_ce_o = 0, ram_we_o = 0; ram_addr_o, ram_sel_o and ram_data_o = 0.
- m0_data_o = m1_data_o = ram_data_i at all times; data is valid only when the matching ack is high.
- Latency: request first seen in cycle N -> ack in N+1 at best. One master alone gets one access every 2 cycles. Under contention each master gets at least 1 access per 4 cycles.
- Writes commit at the data_ram clock edge ending the ack cycle. Masters hold addr/data/sel/we stable from ce assertion until ack.
- Reset, whenever asserted, including during an ack cycle:
  - Same cycle: ram_ce_o, ram_we_o, m0_ack_o and m1_ack_o forced 0, so no write commits.
  - Next cycle: state = IDLE, last_gnt = 1.
  - All outputs read 0 while rst is high.
- Simultaneous M0 write / M1 read to the same address in contention: the order is whichever is granted first; no merging.

Optional Feature:
- Macro: RAM_ARB_CPU_PRIO_EN.
- Defined: fixed priority, M0 always wins ties and last_gnt is unused. M1 can be starved while the CPU issues back-to-back accesses; starvation is bounded only by the eligibility rule (M1 wins in the cycle after each M0 ack).
- Undefined: round-robin as above.

Decomposition:
- define.v gets:
  - ArbIdle/ArbGntM0/ArbGntM1 state encodings (2 bits).
  - ArbM0/ArbM1 master IDs.
  - Reuse of RegBus, RstEnable, WriteEnable, ChipEnable.
- One natural sub-module: ram_arb_pick. It is combinational 2-way round-robin/priority selection from (elig0, elig1, last_gnt) to the next grant. It holds the RAM_ARB_CPU_PRIO_EN ifdef, so the FSM module stays feature-free.

Test Plan:
- Reset: rst=1 with m0_ce_i=1, m0_we_i=1 -> ram_ce_o=0, ram_we_o=0, both acks 0; after release the FSM is in IDLE.
- Single master: M0 writes 0xDEADBEEF to 0x10 (sel 4'hF) from cycle 2 -> m0_ack_o=1 in cycle 3 only, m0_stall_o=1 in cycle 2. A later M0 read of 0x10 returns m0_data_o=0xDEADBEEF in its ack cycle.
- Contention, round-robin: m0_ce_i and m1_ce_i both held high for 8 cycles -> acks alternate M0,M1,M0,M1 (M0 first after reset), one ack per cycle. M0 acks = M1 acks = 4 over 8 cycles ±1.
- Byte write: M1 writes 0x000000AA with sel 4'b0001 to 0x20 over 0x11223344 -> later read gives 0x112233AA.
- Dropped request: M1 drops ce in its grant cycle -> ram_ce_o=0, no ack, and the next grant goes to a pending M0.
- Reset mid-ack: rst asserted during an M1 write ack cycle -> ram_we_o=0 and the RAM word is unchanged.
- With RAM_ARB_CPU_PRIO_EN defined: same contention stimulus as the round-robin test -> M0 is granted on every tie.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared encodings for the data_ram arbiter: FSM states, master IDs, reset level.
package ram_arbiter_pkg;

  localparam int unsigned REG_BUS_W = 32;
  localparam int unsigned SEL_BUS_W = REG_BUS_W / 8;

  localparam logic RST_ENABLE = 1'b1;

  localparam logic [1:0] ARB_IDLE   = 2'b00;
  localparam logic [1:0] ARB_GNT_M0 = 2'b01;
  localparam logic [1:0] ARB_GNT_M1 = 2'b10;

  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

  function automatic logic [1:0] gnt_state(input logic id);
    return (id == ARB_M1) ? ARB_GNT_M1 : ARB_GNT_M0;
  endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Two-way grant selection from eligibility and the last-granted master.
// RAM_ARB_CPU_PRIO_EN selects fixed M0 priority instead of round-robin.
module ram_arb_pick
  import ram_arbiter_pkg::*;
(
  input  logic elig0,
  input  logic elig1,
  input  logic last_gnt,
  output logic gnt_vld_c,
  output logic gnt_id_c
);

`ifdef RAM_ARB_CPU_PRIO_EN
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt;

  always_comb begin
    gnt_vld_c = elig0 | elig1;
    gnt_id_c  = elig0 ? ARB_M0 : ARB_M1;
  end
`else
  // On a tie the master that was not granted last wins.
  always_comb begin
    gnt_vld_c = elig0 | elig1;
    gnt_id_c  = elig0 ? ARB_M0 : ARB_M1;
    if (elig0 && elig1) begin
      gnt_id_c = (last_gnt == ARB_M0) ? ARB_M1 : ARB_M0;
    end
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Two-master single-slave data_ram arbiter with registered single-cycle grants.
// Optional build macro: RAM_ARB_CPU_PRIO_EN (fixed CPU priority, handled in ram_arb_pick).
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = REG_BUS_W,
  parameter int unsigned DATA_W = REG_BUS_W,
  parameter int unsigned SEL_W  = SEL_BUS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_ce_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [SEL_W-1:0]  m0_sel_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_ack_o,
  output logic              m0_stall_o,
  input  logic              m1_ce_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [SEL_W-1:0]  m1_sel_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_ack_o,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [SEL_W-1:0]  ram_sel_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       last_gnt;
  logic       elig0;
  logic       elig1;
  logic       gnt_vld;
  logic       gnt_id;

  // A master acked this cycle (ce high while granted) is not eligible next cycle.
  assign elig0 = m0_ce_i & (state != ARB_GNT_M0);
  assign elig1 = m1_ce_i & (state != ARB_GNT_M1);

  ram_arb_pick u_pick (
    .elig0     (elig0),
    .elig1     (elig1),
    .last_gnt  (last_gnt),
    .gnt_vld_c (gnt_vld),
    .gnt_id_c  (gnt_id)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state    <= ARB_IDLE;
      last_gnt <= ARB_M1;
    end else begin
      state <= state_nxt;
      if (gnt_vld) begin
        last_gnt <= gnt_id;
      end
    end
  end

  always_comb begin
    state_nxt  = ARB_IDLE;
    ram_ce_o   = 1'b0;
    ram_we_o   = 1'b0;
    ram_addr_o = '0;
    ram_sel_o  = '0;
    ram_data_o = '0;
    m0_ack_o   = 1'b0;
    m1_ack_o   = 1'b0;
    m0_data_o  = ram_data_i;
    m1_data_o  = ram_data_i;

    if (gnt_vld) begin
      state_nxt = gnt_state(gnt_id);
    end

    case (state)
      ARB_GNT_M0: begin
        ram_ce_o   = m0_ce_i;
        ram_we_o   = m0_we_i;
        ram_addr_o = m0_addr_i;
        ram_sel_o  = m0_sel_i;
        ram_data_o = m0_data_i;
        m0_ack_o   = m0_ce_i;
      end
      ARB_GNT_M1: begin
        ram_ce_o   = m1_ce_i;
        ram_we_o   = m1_we_i;
        ram_addr_o = m1_addr_i;
        ram_sel_o  = m1_sel_i;
        ram_data_o = m1_data_i;
        m1_ack_o   = m1_ce_i;
      end
      default: ;
    endcase

    m0_stall_o = m0_ce_i & ~m0_ack_o;

    // Reset blanks everything immediately so an in-flight write never commits.
    if (rst == RST_ENABLE) begin
      ram_ce_o   = 1'b0;
      ram_we_o   = 1'b0;
      ram_addr_o = '0;
      ram_sel_o  = '0;
      ram_data_o = '0;
      m0_ack_o   = 1'b0;
      m1_ack_o   = 1'b0;
      m0_stall_o = 1'b0;
      m0_data_o  = '0;
      m1_data_o  = '0;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a byte-lane data_ram model.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_ce, m0_we, m1_ce, m1_we;
  logic [31:0] m0_addr, m0_data, m1_addr, m1_data;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m0_stall, m1_ack;
  logic        ram_ce, ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_sel;
  logic [31:0] mem [0:63];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .m0_ce_i    (m0_ce),
    .m0_we_i    (m0_we),
    .m0_addr_i  (m0_addr),
    .m0_sel_i   (m0_sel),
    .m0_data_i  (m0_data),
    .m0_data_o  (m0_rdata),
    .m0_ack_o   (m0_ack),
    .m0_stall_o (m0_stall),
    .m1_ce_i    (m1_ce),
    .m1_we_i    (m1_we),
    .m1_addr_i  (m1_addr),
    .m1_sel_i   (m1_sel),
    .m1_data_i  (m1_data),
    .m1_data_o  (m1_rdata),
    .m1_ack_o   (m1_ack),
    .ram_ce_o   (ram_ce),
    .ram_we_o   (ram_we),
    .ram_addr_o (ram_addr),
    .ram_sel_o  (ram_sel),
    .ram_data_o (ram_wdata),
    .ram_data_i (ram_rdata)
  );

  // data_ram: combinational read, byte-lane write at the clock edge
  assign ram_rdata = mem[ram_addr[7:2]];
  always @(posedge clk) begin
    if (ram_ce && ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_sel[b]) mem[ram_addr[7:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    m0_ce = 0; m0_we = 0; m0_addr = '0; m0_sel = 4'hF; m0_data = '0;
    m1_ce = 0; m1_we = 0; m1_addr = '0; m1_sel = 4'hF; m1_data = '0;
  endtask

  task automatic settle;
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_reset;
    rst = 1;
    m0_ce = 1; m0_we = 1; m0_addr = 32'h10; m0_sel = 4'hF; m0_data = 32'h1234_5678;
    m1_ce = 1; m1_we = 1; m1_addr = 32'h20; m1_data = 32'h8765_4321;
    @(negedge clk);
    n_tests++; if (ram_ce !== 1'b0) begin n_fail++; $display("FAIL reset_ram_ce: got %0h want 0", ram_ce); end
    n_tests++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_ram_we: got %0h want 0", ram_we); end
    n_tests++; if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin n_fail++; $display("FAIL reset_acks: got %0h/%0h want 0/0", m0_ack, m1_ack); end
    n_tests++; if (m0_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0h want 0", m0_stall); end
    n_tests++; if (m0_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_m0_data: got %h want 0", m0_rdata); end
    tick();
    rst = 0; m0_we = 0; m1_ce = 0; m1_we = 0;
    @(negedge clk);
    n_tests++; if (m0_ack !== 1'b0 || m0_stall !== 1'b1) begin n_fail++; $display("FAIL post_reset_idle: got ack=%0h stall=%0h want 0/1", m0_ack, m0_stall); end
    tick();
    @(negedge clk);
    n_tests++; if (m0_ack !== 1'b1) begin n_fail++; $display("FAIL post_reset_ack: got %0h want 1", m0_ack); end
    n_tests++; if (m0_rdata !== 32'hA5A5_0004) begin n_fail++; $display("FAIL reset_no_write: got %h want a5a50004", m0_rdata); end
    tick();
    clear_inputs();
  endtask

  task automatic test_single;
    settle();
    m0_ce = 1; m0_we = 1; m0_addr = 32'h10; m0_sel = 4'hF; m0_data = 32'hDEAD_BEEF;
    @(negedge clk);
    n_tests++; if (m0_ack !== 1'b0 || m0_stall !== 1'b1) begin n_fail++; $display("FAIL single_req_cycle: got ack=%0h stall=%0h want 0/1", m0_ack, m0_stall); end
    tick();
    @(negedge clk);
    n_tests++; if (m0_ack !== 1'b1 || m0_stall !== 1'b0) begin n_fail++; $display("FAIL single_ack_cycle: got ack=%0h stall=%0h want 1/0", m0_ack, m0_stall); end
    n_tests++; if (ram_ce !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 32'h10 || ram_wdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL single_ram_bus: got ce=%0h we=%0h addr=%h data=%h want 1/1/10/deadbeef", ram_ce, ram_we, ram_addr, ram_wdata); end
    tick();
    clear_inputs();
    @(negedge clk);
    n_tests++; if (m0_ack !== 1'b0) begin n_fail++; $display("FAIL single_ack_once: got %0h want 0", m0_ack); end
    m0_ce = 1; m0_addr = 32'h10;
    tick();
    @(negedge clk);
    n_tests++; if (m0_ack !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_readback: got ack=%0h data=%h want 1/deadbeef", m0_ack, m0_rdata); end
    tick();
    clear_inputs();
  endtask

  task automatic test_contention;
    int c0, c1;
    logic e0, e1;
    c0 = 0; c1 = 0;
    clear_inputs();
    rst = 1;
    tick();
    rst = 0;
    m0_ce = 1; m0_addr = 32'h10;
    m1_ce = 1; m1_addr = 32'h20;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      e0 = (i % 2) == 1;
      e1 = (i > 0) && ((i % 2) == 0);
      if (m0_ack === 1'b1) c0++;
      if (m1_ack === 1'b1) c1++;
      n_tests++; if (m0_ack !== e0 || m1_ack !== e1) begin n_fail++; $display("FAIL contention_cycle%0d: got ack0=%0h ack1=%0h want %0h/%0h", i, m0_ack, m1_ack, e0, e1); end
      tick();
    end
    n_tests++; if (c0 != 4 || c1 != 4) begin n_fail++; $display("FAIL contention_counts: got m0=%0d m1=%0d want 4/4", c0, c1); end
    clear_inputs();
  endtask

  task automatic test_byte_write;
    mem[8] <= 32'h1122_3344;
    settle();
    m1_ce = 1; m1_we = 1; m1_addr = 32'h20; m1_sel = 4'b0001; m1_data = 32'h0000_00AA;
    @(negedge clk);
    n_tests++; if (m1_ack !== 1'b0) begin n_fail++; $display("FAIL byte_req_cycle: got %0h want 0", m1_ack); end
    tick();
    @(negedge clk);
    n_tests++; if (m1_ack !== 1'b1 || ram_we !== 1'b1 || ram_sel !== 4'b0001) begin
      n_fail++; $display("FAIL byte_ack_cycle: got ack=%0h we=%0h sel=%h want 1/1/1", m1_ack, ram_we, ram_sel); end
    tick();
    clear_inputs();
    m1_ce = 1; m1_addr = 32'h20;
    tick();
    @(negedge clk);
    n_tests++; if (m1_ack !== 1'b1 || m1_rdata !== 32'h1122_33AA) begin n_fail++; $display("FAIL byte_readback: got ack=%0h data=%h want 1/112233aa", m1_ack, m1_rdata); end
    tick();
    clear_inputs();
  endtask

  task automatic test_dropped;
    settle();
    m1_ce = 1; m1_addr = 32'h20;
    tick();
    m1_ce = 0;
    m0_ce = 1; m0_addr = 32'h10;
    @(negedge clk);
    n_tests++; if (ram_ce !== 1'b0 || m1_ack !== 1'b0 || m0_ack !== 1'b0) begin
      n_fail++; $display("FAIL dropped_wasted: got ce=%0h ack1=%0h ack0=%0h want 0/0/0", ram_ce, m1_ack, m0_ack); end
    tick();
    @(negedge clk);
    n_tests++; if (m0_ack !== 1'b1 || ram_ce !== 1'b1 || ram_addr !== 32'h10) begin
      n_fail++; $display("FAIL dropped_next_m0: got ack0=%0h ce=%0h addr=%h want 1/1/10", m0_ack, ram_ce, ram_addr); end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid_ack;
    mem[12] <= 32'h5566_7788;
    settle();
    m1_ce = 1; m1_we = 1; m1_addr = 32'h30; m1_sel = 4'hF; m1_data = 32'hCAFE_F00D;
    tick();
    rst = 1;
    @(negedge clk);
    n_tests++; if (ram_we !== 1'b0 || ram_ce !== 1'b0 || m1_ack !== 1'b0) begin
      n_fail++; $display("FAIL midack_blank: got we=%0h ce=%0h ack1=%0h want 0/0/0", ram_we, ram_ce, m1_ack); end
    tick();
    rst = 0;
    clear_inputs();
    m0_ce = 1; m0_addr = 32'h30;
    @(negedge clk);
    n_tests++; if (mem[12] !== 32'h5566_7788) begin n_fail++; $display("FAIL midack_mem: got %h want 55667788", mem[12]); end
    n_tests++; if (m0_ack !== 1'b0) begin n_fail++; $display("FAIL midack_idle: got %0h want 0", m0_ack); end
    tick();
    @(negedge clk);
    n_tests++; if (m0_ack !== 1'b1 || m0_rdata !== 32'h5566_7788) begin n_fail++; $display("FAIL midack_readback: got ack=%0h data=%h want 1/55667788", m0_ack, m0_rdata); end
    tick();
    clear_inputs();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
    clear_inputs();
    rst = 1;
    test_reset();
    test_single();
    test_contention();
    test_byte_write();
    test_dropped();
    test_reset_mid_ack();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
